// File: rtl/multi_key_beeper.sv
// Key-driven buzzer: per-key debounce, tone select and square-wave PWM.
// Play modes: momentary, toggle-latch, timed one-shot, silent.
module multi_key_beeper #(
  parameter int NUM_KEYS = 3,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int DIV_W = 18,
  parameter logic [NUM_KEYS*DIV_W-1:0] TONE_DIVS =
    {18'd151686, 18'd170262, 18'd191110},
  parameter int ONESHOT_CYC = 25_000_000,
  localparam int KW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key,
  input  logic [1:0]          mode,
  output logic                pwm,
  output logic                busy,
  output logic [KW-1:0]       active_key
);

  localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int SW = (ONESHOT_CYC > 1) ? $clog2(ONESHOT_CYC) : 1;

  typedef enum logic {IDLE, PLAY} state_t;

  logic [NUM_KEYS-1:0] s1, s2, stable, press;
  logic [DW-1:0]       db_cnt [NUM_KEYS];

  state_t           state, nstate;
  logic [KW-1:0]    sel, nsel;
  logic [DIV_W-1:0] div_cnt;
  logic [SW-1:0]    shot_cnt;
  logic [1:0]       mode_q;
  logic             shot_load;

  logic             any_prs, any_evt;
  logic [KW-1:0]    prs_idx, evt_idx;
  logic [DIV_W-1:0] tone;

  // Stable levels reset to released, so held keys must re-debounce.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= '1;
      s2     <= '1;
      stable <= '1;
      press  <= '0;
      for (int i = 0; i < NUM_KEYS; i++)
        db_cnt[i] <= '0;
    end else begin
      s1 <= key;
      s2 <= s1;
      for (int i = 0; i < NUM_KEYS; i++) begin
        press[i] <= 1'b0;
        if (s2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DW'(DEBOUNCE_CYC - 1)) begin
          stable[i] <= s2[i];
          db_cnt[i] <= '0;
          press[i]  <= ~s2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Descending scan leaves the lowest index as the winner.
  always_comb begin
    any_prs = 1'b0;
    prs_idx = '0;
    any_evt = 1'b0;
    evt_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (!stable[i]) begin
        any_prs = 1'b1;
        prs_idx = KW'(i);
      end
      if (press[i]) begin
        any_evt = 1'b1;
        evt_idx = KW'(i);
      end
    end
  end

  assign tone = TONE_DIVS[int'(sel)*DIV_W +: DIV_W];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate    = state;
    nsel      = sel;
    shot_load = 1'b0;
    if (mode != mode_q || mode == 2'b11) begin
      nstate = IDLE;
    end else begin
      unique case (mode)
        2'b00: begin
          if (any_prs) begin
            nstate = PLAY;
            nsel   = prs_idx;
          end else begin
            nstate = IDLE;
          end
        end
        2'b01: begin
          if (any_evt) begin
            if (state == IDLE) begin
              nstate = PLAY;
              nsel   = evt_idx;
            end else if (sel == evt_idx) begin
              nstate = IDLE;
            end else begin
              nsel = evt_idx;
            end
          end
        end
        default: begin
          if (any_evt) begin
            nstate    = PLAY;
            nsel      = evt_idx;
            shot_load = 1'b1;
          end else if (state == PLAY && shot_cnt == '0) begin
            nstate = IDLE;
          end
        end
      endcase
    end
  end

  always_comb begin
    busy       = (state == PLAY);
    active_key = sel;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel      <= '0;
      div_cnt  <= '0;
      shot_cnt <= '0;
      mode_q   <= mode;
      pwm      <= 1'b0;
    end else begin
      sel    <= nsel;
      mode_q <= mode;
      pwm    <= (state == PLAY) && (div_cnt < (tone >> 1));
      // Entering PLAY or switching tone restarts the waveform.
      if (nstate == IDLE || state == IDLE || nsel != sel)
        div_cnt <= '0;
      else if (div_cnt == tone - 1'b1)
        div_cnt <= '0;
      else
        div_cnt <= div_cnt + 1'b1;
      if (shot_load)
        shot_cnt <= SW'(ONESHOT_CYC - 1);
      else if (state == PLAY && shot_cnt != '0)
        shot_cnt <= shot_cnt - 1'b1;
    end
  end

endmodule

// File: doc/multi_key_beeper.md
# multi_key_beeper

Parametrised key-driven tone generator for the buzzer path. It combines per-key debouncing, tone selection and square-wave PWM generation in one block for NUM_KEYS raw push-buttons. It adds three play modes: momentary, toggle-latch and timed one-shot. It sits directly between the board key pins and the buzzer pin, and replaces the separate debounce-plus-beep pairing.

## Interface
Parameters:
- NUM_KEYS, 3, number of raw keys; key i selects tone i
- DEBOUNCE_CYC, 1_000_000, cycles a synchronised key level must hold before it is accepted (20 ms at 50 MHz)
- DIV_W, 18, width of one tone divider
- TONE_DIVS, {18'd151686, 18'd170262, 18'd191110}, packed NUM_KEYS*DIV_W vector; slice i is the tone-i period in clk cycles (E4/D4/C4 at 50 MHz); every slice must be ≥ 2
- ONESHOT_CYC, 25_000_000, tone duration in one-shot mode (0.5 s)

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- key  input  NUM_KEYS  raw buttons, active-low (0 = pressed), asynchronous to clk
- mode  input  2  00 momentary, 01 toggle, 10 one-shot, 11 silent
- pwm  output  1  buzzer drive, 50 % duty square wave at the selected tone
- busy  output  1  high while the FSM is in PLAY
- active_key  output  $clog2(NUM_KEYS) (min 1)  index of the tone currently playing; holds its last value in IDLE

## Operation
- Per key: a 2-flop synchroniser, then a debounce counter. The counter clears whenever the synchronised level equals the stable level. When it reaches DEBOUNCE_CYC-1, the stable level takes the synchronised level and the counter clears.
- Press event: stable 1→0. Release event: stable 0→1. Each event is a 1-cycle pulse.
- Simultaneous events or held keys: the lowest index wins.
- FSM states: IDLE, PLAY. Internal registers: sel (tone index), div_cnt (DIV_W bits), shot_cnt (ONESHOT timer), mode_q (registered mode).
- Momentary (00):
  - IDLE→PLAY when any stable key is pressed; sel = lowest pressed index.
  - In PLAY, sel tracks the lowest pressed index.
  - PLAY→IDLE when no key is pressed.
- Toggle (01), press event on key k:
  - From IDLE → PLAY with sel=k.
  - From PLAY with sel==k → IDLE.
  - From PLAY with sel≠k → stay in PLAY with sel=k.
  - Release events are ignored.
- One-shot (10):
  - A press event on k → PLAY with sel=k and shot_cnt loaded to ONESHOT_CYC-1.
  - shot_cnt decrements each cycle; PLAY→IDLE on the cycle it equals 0.
  - A press event during PLAY reloads the timer and sets sel=k.
- Silent (11): the FSM is forced to IDLE; events are discarded.
- Mode change: when mode differs from mode_q, the FSM goes to IDLE and mode_q updates that cycle. Events in that cycle are discarded.
- Tone generator:
  - div_cnt counts 0..TONE_DIVS[sel]-1 and wraps to 0.
  - div_cnt clears on IDLE→PLAY and on any change of sel.
  - pwm register = (state==PLAY) && (div_cnt < TONE_DIVS[sel]>>1).
  - Odd divider: the high phase is floor(div/2) cycles.
- In IDLE, pwm=0 and div_cnt is held at 0.

## Timing
- Reset values: pwm=0, busy=0, active_key=0, state IDLE, all stable levels=1 (released), counters 0, mode_q=mode input sampled during reset.
- Raw edge to stable change: 2 synchroniser cycles + DEBOUNCE_CYC cycles; any bounce restarts the count.
- The event pulse is valid in the cycle the stable level changes (cycle t).
- State, busy and active_key update at t+1. pwm first goes high at t+2 (registered from the t+1 state).
- Tone period is exactly TONE_DIVS[sel] cycles.
- A sel switch restarts the waveform: the high phase begins 1 cycle after the switch.
- One-shot: busy is high for exactly ONESHOT_CYC cycles per press, absent reloads.
- rst asserted mid-tone: pwm and busy are 0 on the next edge. Keys held through reset must be re-debounced before acting.

## Test plan
Bench parameters for all scenarios: DEBOUNCE_CYC=4, TONE_DIVS={12,10,8}, ONESHOT_CYC=40.

- Reset, bounce filtering:
  - Stimulus: reset, then key0 toggled every 2 cycles for 20 cycles, then held low.
  - Required: no press event during bouncing; press event exactly 6 cycles after the final low; pwm stays 0 until the FSM enters PLAY.
- Momentary priority:
  - Stimulus: mode=00, hold key1 then also key0.
  - Required: with key1 alone, period 10 (5 high / 5 low) and active_key=1. After key0 stabilises, active_key=0, period 8, waveform restarts. Release all → busy=0 at t+1.
- Toggle:
  - Stimulus: mode=01; press/release key2; press/release key2 again; then key0 and key1 pressed in the same cycle.
  - Required: first press → PLAY, period 12; second press → IDLE, pwm=0; simultaneous press → sel=0.
- One-shot reload:
  - Stimulus: mode=10; press key1; press key2 after 25 cycles of PLAY.
  - Required: busy high 25+40 cycles total, active_key=2 after the reload, then IDLE.
- Mode change and reset mid-tone:
  - Stimulus: playing in toggle mode, mode→11.
  - Required: busy=0 next edge.
  - Stimulus: playing in momentary mode, assert rst for 1 cycle.
  - Required: pwm=0, busy=0 next edge; tone resumes only after re-debounce of the held key.
